// File: rtl/i281_trace_pkg.sv
// Shared types and entry layout for the i281 execution trace buffer.
package i281_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  // Entry layout {cycle, instr, state, regs, flags}; LSB offsets for the default configuration.
  localparam int DEF_FLAGS_LSB = 0;
  localparam int DEF_REGS_LSB  = 4;
  localparam int DEF_STATE_LSB = 36;
  localparam int DEF_OPC_LSB   = 44;
  localparam int DEF_CYC_LSB   = 49;

  function automatic int entry_width(input int cyc_w, input int opc_w, input int st_w,
                                     input int num_regs, input int reg_w, input int flag_w);
    return cyc_w + opc_w + st_w + num_regs * reg_w + flag_w;
  endfunction

endpackage

// File: rtl/i281_trace_mem.sv
// Trace storage: simple dual-port RAM, one write port, registered read port.
module i281_trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/i281_trace_buffer.sv
// Execution trace capture for the i281 CPU: circular buffer, programmable
// opcode/state trigger with post-trigger count, oldest-first readback.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not capturing; buffer contents held
// ST_ARMED | capturing pre-trigger samples, oldest overwritten on wrap
// ST_POST  | trigger seen; capturing the remaining post-trigger samples
// ST_DONE  | trace frozen until the next arm
module i281_trace_buffer
  import i281_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 8,
  parameter int OPC_W    = 5,
  parameter int STATE_W  = 8,
  parameter int FLAG_W   = 4,
  parameter int CYC_W    = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int ENTRY_W = entry_width(CYC_W, OPC_W, STATE_W, NUM_REGS, REG_W, FLAG_W)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      sample_valid,
  input  logic [OPC_W-1:0]          instr,
  input  logic [STATE_W-1:0]        state,
  input  logic [NUM_REGS*REG_W-1:0] regs,
  input  logic [FLAG_W-1:0]         flags,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      trig_opc_en,
  input  logic [OPC_W-1:0]          trig_opc,
  input  logic                      trig_st_en,
  input  logic [STATE_W-1:0]        trig_st,
  input  logic [AW-1:0]             post_count,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_idx,
  output logic [ENTRY_W-1:0]        rd_data,
  output logic                      rd_valid,
  output logic                      rd_err,
  output logic [1:0]                fsm_state,
  output logic [AW:0]               count,
  output logic [AW-1:0]             trig_idx,
  output logic [CYC_W-1:0]          cycle
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

  trace_state_t       st_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      remaining;
  logic               full;
  logic               capturing;
  logic               trig_hit;
  logic               qual;
  logic [ENTRY_W-1:0] wdata;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      raddr;
  logic               rd_oob;
  logic               rd_re;
  logic [ENTRY_W-1:0] mem_q;

  assign full      = (count == FULL_CNT);
  assign capturing = (st_q == ST_ARMED) || (st_q == ST_POST);
  assign trig_hit  = (trig_opc_en | trig_st_en)
                   & (!trig_opc_en | (instr == trig_opc))
                   & (!trig_st_en  | (state == trig_st));
  assign qual      = run & sample_valid & capturing & !arm;
  assign wdata     = {cycle, instr, state, regs, flags};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q      <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      trig_idx  <= '0;
      cycle     <= '0;
    end else begin
      if (run) cycle <= cycle + 1'b1;

      if (arm) begin
        st_q      <= ST_ARMED;
        wr_ptr    <= '0;
        count     <= '0;
        remaining <= '0;
        trig_idx  <= '0;
      end else begin
        if (qual) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (!full) count <= count + 1'b1;
          if ((st_q == ST_ARMED) && trig_hit) begin
            // trigger entry is the newest one; once full that is the last index
            trig_idx  <= full ? LAST_IDX : count[AW-1:0];
            remaining <= post_count;
            st_q      <= (post_count == '0) ? ST_DONE : ST_POST;
          end else if (st_q == ST_POST) begin
            remaining <= remaining - 1'b1;
            // a write into a full buffer retires the oldest entry
            if (full) trig_idx <= trig_idx - 1'b1;
            if (remaining == AW'(1)) st_q <= ST_DONE;
          end
        end
        if (abort && capturing) st_q <= ST_IDLE;
      end
    end
  end

  assign fsm_state = st_q;

  assign oldest = full ? wr_ptr : '0;
  assign raddr  = oldest + rd_idx;
  assign rd_oob = ({1'b0, rd_idx} >= count);
  assign rd_re  = rd_en & !rd_oob;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & rd_oob;
    end
  end

  i281_trace_mem #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_mem (
    .clock(clock),
    .we   (qual),
    .waddr(wr_ptr),
    .wdata(wdata),
    .re   (rd_re),
    .raddr(raddr),
    .rdata(mem_q)
  );

  // RAM output register has no reset, so data is forced to zero unless a good read is pending
  assign rd_data = (rd_valid && !rd_err) ? mem_q : '0;

endmodule

// File: tb/tb_i281_trace_buffer.sv
// Bench for i281_trace_buffer: directed vector table, hand sequences, and
// random stimulus against a queue-based reference model.
module tb_i281_trace_buffer;

  logic        clock = 0;
  logic        reset;
  logic        run, sample_valid;
  logic [4:0]  instr;
  logic [7:0]  state;
  logic [31:0] regs;
  logic [3:0]  flags;
  logic        arm, abort;
  logic        trig_opc_en, trig_st_en;
  logic [4:0]  trig_opc;
  logic [7:0]  trig_st;
  logic [3:0]  post_count;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic [64:0] rd_data;
  logic        rd_valid, rd_err;
  logic [1:0]  fsm_state;
  logic [4:0]  count;
  logic [3:0]  trig_idx;
  logic [15:0] cycle;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [64:0] q[$];
  int          ms, total, trig_n, post_n;
  bit [15:0]   mcyc;
  bit          mrv, mre;

  i281_trace_buffer dut (
    .clock(clock), .reset(reset), .run(run), .sample_valid(sample_valid),
    .instr(instr), .state(state), .regs(regs), .flags(flags),
    .arm(arm), .abort(abort),
    .trig_opc_en(trig_opc_en), .trig_opc(trig_opc),
    .trig_st_en(trig_st_en), .trig_st(trig_st),
    .post_count(post_count), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .fsm_state(fsm_state), .count(count), .trig_idx(trig_idx), .cycle(cycle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_trig();
    if (trig_n == 0) return 0;
    return trig_n - (total - q.size()) - 1;
  endfunction

  task automatic check_status();
    chk("fsm_state", fsm_state, ms);
    chk("count", count, q.size());
    chk("trig_idx", trig_idx, exp_trig());
    chk("cycle", cycle, mcyc);
    chk("rd_valid", rd_valid, mrv);
    chk("rd_err", rd_err, mre);
  endtask

  task automatic model_reset();
    q.delete();
    ms = 0; total = 0; trig_n = 0; post_n = 0;
    mcyc = 0; mrv = 0; mre = 0;
  endtask

  // advance the model by one clock using the current inputs, then clock the DUT and compare
  task automatic tick();
    int  pre = ms;
    bit  qual, match;
    qual  = run && sample_valid && (pre == 1 || pre == 2) && !arm;
    match = (trig_opc_en || trig_st_en) && (!trig_opc_en || instr == trig_opc)
            && (!trig_st_en || state == trig_st);
    mrv = rd_en;
    mre = rd_en && (int'(rd_idx) >= q.size());
    if (arm) begin
      q.delete(); total = 0; trig_n = 0; ms = 1;
    end else begin
      if (qual) begin
        q.push_back({mcyc, instr, state, regs, flags});
        total++;
        if (q.size() > 16) void'(q.pop_front());
        if (pre == 1 && match) begin
          trig_n = total; post_n = int'(post_count);
          ms = (post_n == 0) ? 3 : 2;
        end else if (pre == 2 && total - trig_n == post_n) begin
          ms = 3;
        end
      end
      if (abort && (pre == 1 || pre == 2)) ms = 0;
    end
    if (run) mcyc++;
    @(posedge clock); #1;
    check_status();
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; sample_valid = 0; rd_en = 0; rd_idx = 0;
  endtask

  task automatic pulse_arm();
    idle_inputs(); arm = 1; tick(); arm = 0;
  endtask

  task automatic pulse_abort();
    idle_inputs(); abort = 1; tick(); abort = 0;
  endtask

  task automatic sample(input logic [4:0] op, input logic [7:0] st, input logic [31:0] r);
    sample_valid = 1; instr = op; state = st; regs = r; flags = r[3:0] ^ 4'h5;
    tick();
    sample_valid = 0;
  endtask

  task automatic read_chk(input int idx);
    logic [64:0] exp;
    exp = (idx >= q.size()) ? 65'd0 : q[idx];
    rd_en = 1; rd_idx = idx[3:0];
    tick();
    rd_en = 0;
    chk("rd_data", rd_data, exp);
  endtask

  typedef struct {
    bit       arm;
    bit       abort;
    bit       sv;
    bit [4:0] opc;
    int       exp_fsm;
    int       exp_cnt;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [64:0] prev;
    reset = 0; run = 1; instr = 0; state = 0; regs = 0; flags = 0;
    trig_opc_en = 0; trig_st_en = 0; trig_opc = 0; trig_st = 0; post_count = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_status();
    chk("rst_rd_data", rd_data, 65'd0);
    @(negedge clock); reset = 1;

    // arm, five samples with trigger disabled, abort
    vt[0] = '{1, 0, 0, 5'd0, 1, 0};
    vt[1] = '{0, 0, 1, 5'd7, 1, 1};
    vt[2] = '{0, 0, 1, 5'd3, 1, 2};
    vt[3] = '{0, 0, 0, 5'd7, 1, 2};
    vt[4] = '{0, 0, 1, 5'd7, 1, 3};
    vt[5] = '{0, 0, 1, 5'd1, 1, 4};
    vt[6] = '{0, 0, 1, 5'd2, 1, 5};
    vt[7] = '{0, 1, 0, 5'd0, 0, 5};
    vt[8] = '{0, 0, 1, 5'd4, 0, 5};
    vt[9] = '{0, 0, 0, 5'd0, 0, 5};
    trig_opc = 5'd7;
    for (int i = 0; i < 10; i++) begin
      arm = vt[i].arm; abort = vt[i].abort; sample_valid = vt[i].sv;
      instr = vt[i].opc; state = 8'(i); regs = 32'(i * 3); flags = 4'(i);
      tick();
      chk("vec_fsm", fsm_state, vt[i].exp_fsm);
      chk("vec_count", count, vt[i].exp_cnt);
    end
    idle_inputs();
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      read_chk(i);
      if (i > 0 && i < 5) chk("stamp_increasing", rd_data[64:49] > prev[64:49], 1);
      prev = rd_data;
    end
    chk("oob_err", rd_err, 1);
    tick();
    chk("rd_valid_drop", rd_valid, 0);

    // 20 samples, no trigger: wrap keeps the newest 16
    pulse_arm();
    for (int i = 1; i <= 20; i++) sample(5'd1, 8'd2, 32'(i));
    pulse_abort();
    chk("wrap_count", count, 16);
    read_chk(0);
    chk("wrap_idx0", rd_data[11:4], 5);
    read_chk(15);
    chk("wrap_idx15", rd_data[11:4], 20);

    // opcode trigger at sample 10 with three post samples
    trig_opc_en = 1; trig_opc = 5'd7; post_count = 4'd3;
    pulse_arm();
    for (int i = 1; i <= 13; i++) sample((i == 10) ? 5'd7 : 5'd1, 8'd4, 32'(i));
    chk("opc_done", fsm_state, 3);
    chk("opc_count", count, 13);
    chk("opc_trig_idx", trig_idx, 9);
    for (int i = 0; i < 3; i++) sample(5'd7, 8'd4, 32'(100 + i));
    chk("opc_frozen", count, 13);
    read_chk(9);
    chk("opc_trig_entry", rd_data[11:4], 10);

    // combined opcode+state trigger after a long wrap, no post samples
    trig_opc_en = 1; trig_st_en = 1; trig_opc = 5'd11; trig_st = 8'd9; post_count = 0;
    pulse_arm();
    for (int i = 1; i <= 30; i++)
      if (i % 2) sample(5'd11, 8'd3, 32'(i)); else sample(5'd2, 8'd9, 32'(i));
    sample(5'd11, 8'd9, 32'd31);
    chk("st_done", fsm_state, 3);
    chk("st_count", count, 16);
    chk("st_trig_idx", trig_idx, 15);
    read_chk(15);
    chk("st_entry_state", rd_data[43:36], 9);
    chk("st_entry_opc", rd_data[48:44], 11);

    // trigger near the wrap point so post samples retire older entries
    trig_st_en = 0; trig_opc = 5'd7; post_count = 4'd5;
    pulse_arm();
    for (int i = 1; i <= 19; i++) sample((i == 14) ? 5'd7 : 5'd1, 8'd0, 32'(i));
    chk("wrap_post_trig_idx", trig_idx, 10);

    // arm during POST, then arm and abort together
    post_count = 4'd6;
    pulse_arm();
    sample(5'd7, 8'd0, 32'd1);
    sample(5'd1, 8'd0, 32'd2);
    chk("post_state", fsm_state, 2);
    pulse_arm();
    chk("rearm_fsm", fsm_state, 1);
    chk("rearm_count", count, 0);
    chk("rearm_trig", trig_idx, 0);
    idle_inputs(); arm = 1; abort = 1; tick(); idle_inputs();
    chk("arm_over_abort", fsm_state, 1);
    pulse_abort();
    chk("abort_idle", fsm_state, 0);

    // reset in the middle of POST
    pulse_arm();
    sample(5'd7, 8'd0, 32'd1);
    sample(5'd1, 8'd0, 32'd2);
    rd_en = 1; rd_idx = 0; tick(); rd_en = 0;
    #3 reset = 0;
    #1;
    model_reset();
    check_status();
    chk("rst_mid_rd_data", rd_data, 65'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1;
    #1 chk("cycle_restart", cycle, 0);
    tick();
    chk("cycle_after_release", cycle, 1);

    // random stimulus against the model
    for (int seg = 0; seg < 12; seg++) begin
      trig_opc_en = 1'($urandom);
      trig_st_en  = 1'($urandom);
      trig_opc    = 5'($urandom_range(0, 3));
      trig_st     = 8'($urandom_range(0, 3));
      post_count  = 4'($urandom_range(0, 15));
      pulse_arm();
      for (int c = 0; c < 150; c++) begin
        run          = ($urandom_range(0, 9) != 0);
        sample_valid = 1'($urandom);
        instr        = 5'($urandom_range(0, 3));
        state        = 8'($urandom_range(0, 3));
        regs         = $urandom;
        flags        = 4'($urandom);
        arm          = ($urandom_range(0, 59) == 0);
        abort        = ($urandom_range(0, 119) == 0);
        tick();
      end
      run = 1;
      if (ms == 1 || ms == 2) pulse_abort();
      idle_inputs();
      for (int i = 0; i < 16; i++) read_chk(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
